vram_arbiter: RTL

//  Slot-based arbiter for the single-port 512Kx8 SRAM. Shares it between the screen fetcher (hard

---
 rtl/vram_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Slot arbiter for the shared screen SRAM (screen > CPU > DMA), one 2-cycle slot per ck14, screen read data passed through.
// Grant at ck14, rdata/ack 3 clk28 after grant; requests wait for the next ck14, DMA may starve.
module vram_arbiter #(
    parameter logic [3:0] SCR_PHASE = 4'd10
) (
    input  logic        clk28,
    input  logic        rst_n,
    input  logic        ck14,
    input  logic [3:0]  slot_phase,
    input  logic        scr_bank7,
    output logic        scr_allow,
    input  logic        scr_fetch_nx,
    input  logic [14:0] scr_addr,
    output logic [7:0]  scr_data,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic [18:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    output logic        cpu_ack,
    output logic        cpu_wait,
    input  logic        aux_req,
    input  logic        aux_wr,
    input  logic [18:0] aux_addr,
    input  logic [7:0]  aux_wdata,
    output logic [7:0]  aux_rdata,
    output logic        aux_ack,
    output logic [18:0] sram_addr,
    input  logic [7:0]  sram_dq_i,
    output logic [7:0]  sram_dq_o,
    output logic        sram_dq_oe,
    output logic        sram_we_n,
    output logic        sram_oe_n
);
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_SCR  = 2'd1,
        OWN_CPU  = 2'd2,
        OWN_AUX  = 2'd3
    } owner_t;

    localparam logic [3:0] SCR_PHASE_B = SCR_PHASE + 4'd1;

    owner_t      owner;
    owner_t      owner_nx;
    logic        half;
    logic        pending;
    logic        cpu_req_d;
    logic        aux_done;
    logic        slot_wr;
    logic [7:0]  slot_wdata;
    logic        cpu_edge;
    logic        cpu_want;
    logic        aux_want;
    logic        closing;
    logic        bus_act;
    logic [18:0] addr_nx;
    logic        wr_nx;
    logic [7:0]  wdata_nx;
    logic        unused_scr_msb;

    // Screen addresses are 0x4000-based; only the offset within the 16K page matters.
    assign unused_scr_msb = scr_addr[14];

    assign cpu_edge = cpu_req & ~cpu_req_d;
    assign cpu_want = pending | cpu_edge;
    // The slot currently serving DMA must not be re-granted before its ack marks the request done.
    assign aux_want = aux_req & ~aux_done & (owner != OWN_AUX);
    assign closing  = ck14 & half;

    always_comb begin
        owner_nx = owner;
        if (ck14) begin
            if (scr_fetch_nx) begin
                owner_nx = OWN_SCR;
            end else if (cpu_want) begin
                owner_nx = OWN_CPU;
            end else if (aux_want) begin
                owner_nx = OWN_AUX;
            end else begin
                owner_nx = OWN_IDLE;
            end
        end
    end

    always_comb begin
        addr_nx  = sram_addr;
        wr_nx    = 1'b0;
        wdata_nx = slot_wdata;
        case (owner_nx)
            OWN_SCR: addr_nx = {2'b00, (scr_bank7 ? 3'd7 : 3'd5), scr_addr[13:0]};
            OWN_CPU: begin
                addr_nx  = cpu_addr;
                wr_nx    = cpu_wr;
                wdata_nx = cpu_wdata;
            end
            OWN_AUX: begin
                addr_nx  = aux_addr;
                wr_nx    = aux_wr;
                wdata_nx = aux_wdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            owner <= OWN_IDLE;
            half  <= 1'b0;
        end else begin
            owner <= owner_nx;
            half  <= ~ck14;
        end
    end

    // Slot attributes are latched at the grant so the bus stays stable for both halves.
    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            sram_addr  <= 19'd0;
            slot_wr    <= 1'b0;
            slot_wdata <= 8'd0;
        end else if (ck14 && (owner_nx != OWN_IDLE)) begin
            sram_addr  <= addr_nx;
            slot_wr    <= wr_nx;
            slot_wdata <= wdata_nx;
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            cpu_req_d <= 1'b0;
            pending   <= 1'b0;
        end else begin
            cpu_req_d <= cpu_req;
            pending   <= cpu_want & ~(ck14 & (owner_nx == OWN_CPU));
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            cpu_ack   <= 1'b0;
            cpu_rdata <= 8'd0;
        end else begin
            cpu_ack <= closing && (owner == OWN_CPU);
            if (closing && (owner == OWN_CPU) && !slot_wr) begin
                cpu_rdata <= sram_dq_i;
            end
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            aux_ack   <= 1'b0;
            aux_rdata <= 8'd0;
            aux_done  <= 1'b0;
        end else begin
            aux_ack <= closing && (owner == OWN_AUX);
            if (closing && (owner == OWN_AUX) && !slot_wr) begin
                aux_rdata <= sram_dq_i;
            end
            if (closing && (owner == OWN_AUX)) begin
                aux_done <= 1'b1;
            end else if (!aux_req) begin
                aux_done <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk28 or negedge rst_n) begin
        if (!rst_n) begin
            scr_allow <= 1'b0;
        end else begin
            scr_allow <= (slot_phase == SCR_PHASE) || (slot_phase == SCR_PHASE_B);
        end
    end

    // Strobes decode straight from reset-cleared flops so reset idles the bus without waiting for a clock.
    assign bus_act    = (owner != OWN_IDLE);
    assign sram_oe_n  = ~(bus_act & ~slot_wr);
    assign sram_dq_oe = bus_act & slot_wr;
    assign sram_we_n  = ~(bus_act & slot_wr & half);
    assign sram_dq_o  = slot_wdata;
    assign scr_data   = sram_dq_i;
    assign cpu_wait   = pending;

`ifndef SYNTHESIS
    a_scr_window: assert property (@(posedge clk28) disable iff (!rst_n)
        (ck14 && scr_fetch_nx) |-> scr_allow)
        else $error("screen fetch requested outside its window");
`endif

endmodule
